mem_arbiter: RTL and testbench

Shares the single main-memory block port between the instruction cache (refill reads) and the data cache (refill reads and write-backs). Sits between both cache controllers and the 128-bit-block main memory. Each cache sees a private busywait port; the arbiter grants one requester at a time, forwards its command, and returns read data in a per-requester register.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//
// Purpose:
//   Shares the single 128-bit block port of main memory between the
//   instruction cache (refill reads) and the data cache (refill reads and
//   write-backs). One requester is granted at a time. The arbiter forwards
//   that requester's command to memory and returns read data in a register
//   private to each requester.
//
// Optional feature (compile-time macro):
//   MEM_ARB_ROUND_ROBIN_EN - when defined, a tie in IDLE goes to the requester
//                            that did not win the last grant. When undefined,
//                            the d-cache always wins ties.
//
// Ports:
//   CLK            in   clock, all state updates on the rising edge
//   RESET          in   synchronous active-high reset
//   I_READ         in   i-cache block read request
//   I_ADDR         in   i-cache block address
//   I_READDATA     out  registered block returned to the i-cache
//   I_BUSYWAIT     out  stall to the i-cache
//   D_READ         in   d-cache block read request
//   D_WRITE        in   d-cache block write request (wins over D_READ)
//   D_ADDR         in   d-cache block address
//   D_WRITEDATA    in   d-cache write block
//   D_READDATA     out  registered block returned to the d-cache
//   D_BUSYWAIT     out  stall to the d-cache
//   MEM_READ       out  memory read command
//   MEM_WRITE      out  memory write command
//   MEM_ADDR       out  memory block address
//   MEM_WRITEDATA  out  memory write block
//   MEM_READDATA   in   memory read block
//   MEM_BUSYWAIT   in   memory busy

module mem_arbiter #(
    parameter int ADDR_W  = 28,
    parameter int BLOCK_W = 128
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               I_READ,
    input  logic [ADDR_W-1:0]  I_ADDR,
    output logic [BLOCK_W-1:0] I_READDATA,
    output logic               I_BUSYWAIT,
    input  logic               D_READ,
    input  logic               D_WRITE,
    input  logic [ADDR_W-1:0]  D_ADDR,
    input  logic [BLOCK_W-1:0] D_WRITEDATA,
    output logic [BLOCK_W-1:0] D_READDATA,
    output logic               D_BUSYWAIT,
    output logic               MEM_READ,
    output logic               MEM_WRITE,
    output logic [ADDR_W-1:0]  MEM_ADDR,
    output logic [BLOCK_W-1:0] MEM_WRITEDATA,
    input  logic [BLOCK_W-1:0] MEM_READDATA,
    input  logic               MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } arbState_t;

    arbState_t          state_q, state_d;
    logic               ownerD_q, ownerD_d;
    logic               firstCycle_q, firstCycle_d;
    logic               writeOp_q, writeOp_d;
    logic [BLOCK_W-1:0] iReadData_q, iReadData_d;
    logic [BLOCK_W-1:0] dReadData_q, dReadData_d;

    logic iPending;
    logic dPending;
    logic dWinsTie;
    logic inGrant;

    assign iPending = I_READ;
    assign dPending = D_READ | D_WRITE;

    // Tie-break between simultaneous requests in IDLE. With round robin the
    // requester that did not own the last grant wins, so each side waits for
    // at most one transaction of the other.
`ifdef MEM_ARB_ROUND_ROBIN_EN
    assign dWinsTie = ~ownerD_q;
`else
    assign dWinsTie = 1'b1;
`endif

    // Next-state logic. A grant records the owner and latches whether the
    // transaction is a write, so the memory command holds its kind even if
    // the owner drops its request before memory finishes. Memory busy is
    // ignored on the edge that ends the first grant cycle, so every
    // transfer shows at least two command cycles to memory. Completing a
    // read captures MEM_READDATA into the owner's register only.
    always_comb begin
        state_d      = state_q;
        ownerD_d     = ownerD_q;
        firstCycle_d = 1'b0;
        writeOp_d    = writeOp_q;
        iReadData_d  = iReadData_q;
        dReadData_d  = dReadData_q;

        case (state_q)
            IDLE: begin
                if (dPending && (!iPending || dWinsTie)) begin
                    state_d      = GRANT_D;
                    ownerD_d     = 1'b1;
                    firstCycle_d = 1'b1;
                    writeOp_d    = D_WRITE;
                end else if (iPending) begin
                    state_d      = GRANT_I;
                    ownerD_d     = 1'b0;
                    firstCycle_d = 1'b1;
                    writeOp_d    = 1'b0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!firstCycle_q && !MEM_BUSYWAIT) begin
                    state_d = DONE;
                    if (!writeOp_q) begin
                        if (state_q == GRANT_I) begin
                            iReadData_d = MEM_READDATA;
                        end else begin
                            dReadData_d = MEM_READDATA;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and returned-data registers. Reset abandons any transfer in
    // flight; the owner falls back to the d-cache so that, with round robin,
    // the first tie after reset goes to the i-cache.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= IDLE;
            ownerD_q     <= 1'b1;
            firstCycle_q <= 1'b0;
            writeOp_q    <= 1'b0;
            iReadData_q  <= '0;
            dReadData_q  <= '0;
        end else begin
            state_q      <= state_d;
            ownerD_q     <= ownerD_d;
            firstCycle_q <= firstCycle_d;
            writeOp_q    <= writeOp_d;
            iReadData_q  <= iReadData_d;
            dReadData_q  <= dReadData_d;
        end
    end

    // Memory command. Outside a grant every memory output is held at zero.
    // The address and write block follow the owner's inputs, which the owner
    // keeps stable while it waits.
    assign inGrant       = (state_q == GRANT_I) || (state_q == GRANT_D);
    assign MEM_READ      = inGrant & ~writeOp_q;
    assign MEM_WRITE     = inGrant & writeOp_q;
    assign MEM_ADDR      = (state_q == GRANT_I) ? I_ADDR :
                           (state_q == GRANT_D) ? D_ADDR : '0;
    assign MEM_WRITEDATA = (state_q == GRANT_D) ? D_WRITEDATA : '0;

    // Stall to each cache. A fresh request stalls in the same cycle. The stall
    // drops only in DONE, and only for the owner that is still requesting.
    assign I_BUSYWAIT = iPending & ~((state_q == DONE) & ~ownerD_q);
    assign D_BUSYWAIT = dPending & ~((state_q == DONE) &  ownerD_q);

    assign I_READDATA = iReadData_q;
    assign D_READDATA = dReadData_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//
// Purpose:
//   Self-checking bench for mem_arbiter. Two randomized cache requesters and
//   a randomly busy memory drive the arbiter. A transaction-level reference
//   model tracks who holds the memory port and when each transfer finishes.
//   The model keeps cycle timestamps for the grant and for completion. It
//   predicts every arbiter output on every cycle.
//
// Optional feature (compile-time macro):
//   MEM_ARB_ROUND_ROBIN_EN - must match the build of the design; selects the
//                            model's tie rule.

module tb_mem_arbiter;

    localparam int AW = 28;
    localparam int BW = 128;

    logic          clock;
    logic          reset;
    logic          iRead;
    logic [AW-1:0] iAddr;
    logic [BW-1:0] iReadData;
    logic          iBusywait;
    logic          dRead;
    logic          dWrite;
    logic [AW-1:0] dAddr;
    logic [BW-1:0] dWriteData;
    logic [BW-1:0] dReadData;
    logic          dBusywait;
    logic          memRead;
    logic          memWrite;
    logic [AW-1:0] memAddr;
    logic [BW-1:0] memWriteData;
    logic [BW-1:0] memReadData;
    logic          memBusywait;

    mem_arbiter #(
        .ADDR_W (AW),
        .BLOCK_W(BW)
    ) dut (
        .CLK          (clock),
        .RESET        (reset),
        .I_READ       (iRead),
        .I_ADDR       (iAddr),
        .I_READDATA   (iReadData),
        .I_BUSYWAIT   (iBusywait),
        .D_READ       (dRead),
        .D_WRITE      (dWrite),
        .D_ADDR       (dAddr),
        .D_WRITEDATA  (dWriteData),
        .D_READDATA   (dReadData),
        .D_BUSYWAIT   (dBusywait),
        .MEM_READ     (memRead),
        .MEM_WRITE    (memWrite),
        .MEM_ADDR     (memAddr),
        .MEM_WRITEDATA(memWriteData),
        .MEM_READDATA (memReadData),
        .MEM_BUSYWAIT (memBusywait)
    );

    // Free-running clock, 10 time units per cycle.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model state. txnOwner: 0 = port free, 1 = i-cache, 2 = d-cache.
    // grantAt is the first cycle of the transfer. doneAt is the cycle in which
    // the owner is released (-1 until memory has finished).
    int            cyc;
    int            txnOwner;
    int            lastWinner;
    int            grantAt;
    int            doneAt;
    bit            txnIsWrite;
    bit            inDone;
    bit            inGrant;
    bit            iSawDone;
    bit            dSawDone;
    logic [BW-1:0] expIData;
    logic [BW-1:0] expDData;

    // Traffic shape for the current phase of the run.
    int reqPct;
    int busyPct;
    int keepPct;

    // Compares one observed value against the model's value and reports any
    // difference.
    task automatic checkOutput(input string tag, input logic [BW-1:0] observed,
                               input logic [BW-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s at cycle %0d: observed %h, expected %h",
                     tag, cyc, observed, expected);
        end
    endtask

    function automatic logic [BW-1:0] randBlock();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic modelReset();
        txnOwner   = 0;
        lastWinner = 2;
        grantAt    = -1;
        doneAt     = -1;
        txnIsWrite = 1'b0;
        expIData   = '0;
        expDData   = '0;
        iSawDone   = 1'b0;
        dSawDone   = 1'b0;
    endtask

    // Drives one cycle of stimulus just after the rising edge. Each cache
    // holds its request and address until it has seen its own stall drop.
    // Then it either issues a new request at once or goes quiet. An owner
    // occasionally abandons its request while memory is still busy.
    task automatic applyStimulus();
        int phase;
        bit newWrite;
        phase = (cyc / 600) % 4;
        case (phase)
            0:       begin reqPct = 30;  busyPct = 50; keepPct = 20;  end
            1:       begin reqPct = 100; busyPct = 0;  keepPct = 100; end
            2:       begin reqPct = 60;  busyPct = 80; keepPct = 50;  end
            default: begin reqPct = 15;  busyPct = 40; keepPct = 100; end
        endcase

        if (txnOwner == 2 && !inDone) begin
            reset = ($urandom_range(0, 79) == 0);
        end else begin
            reset = ($urandom_range(0, 299) == 0);
        end

        memBusywait = ($urandom_range(0, 99) < busyPct);
        memReadData = randBlock();

        if (iRead) begin
            if (iSawDone) begin
                if ($urandom_range(0, 99) < keepPct) begin
                    iAddr = AW'($urandom);
                end else begin
                    iRead = 1'b0;
                end
            end else if (txnOwner == 1 && doneAt < 0 && $urandom_range(0, 99) < 4) begin
                iRead = 1'b0;
            end
        end else if (txnOwner != 1 && $urandom_range(0, 99) < reqPct) begin
            iRead = 1'b1;
            iAddr = AW'($urandom);
        end

        if (dRead || dWrite) begin
            if (dSawDone) begin
                if (phase == 3 || $urandom_range(0, 99) < keepPct) begin
                    newWrite   = $urandom_range(0, 1) == 1;
                    dWrite     = newWrite;
                    dRead      = newWrite ? ($urandom_range(0, 1) == 1) : 1'b1;
                    dAddr      = AW'($urandom);
                    dWriteData = randBlock();
                end else begin
                    dRead  = 1'b0;
                    dWrite = 1'b0;
                end
            end else if (txnOwner == 2 && doneAt < 0 && $urandom_range(0, 99) < 4) begin
                dRead  = 1'b0;
                dWrite = 1'b0;
            end
        end else if (txnOwner != 2 &&
                     (phase == 3 || $urandom_range(0, 99) < reqPct)) begin
            newWrite   = $urandom_range(0, 1) == 1;
            dWrite     = newWrite;
            dRead      = newWrite ? ($urandom_range(0, 1) == 1) : 1'b1;
            dAddr      = AW'($urandom);
            dWriteData = randBlock();
        end
    endtask

    // Compares every arbiter output with what the model predicts for the
    // current cycle.
    task automatic compareCycle();
        logic [AW-1:0] expAddr;
        logic [BW-1:0] expWData;
        inDone  = (txnOwner != 0) && (doneAt == cyc);
        inGrant = (txnOwner != 0) && !inDone;
        expAddr  = !inGrant ? '0 : (txnOwner == 1 ? iAddr : dAddr);
        expWData = (inGrant && txnOwner == 2) ? dWriteData : '0;

        checkOutput("memRead",      BW'(memRead),      BW'(inGrant && !txnIsWrite));
        checkOutput("memWrite",     BW'(memWrite),     BW'(inGrant && txnIsWrite));
        checkOutput("memAddr",      BW'(memAddr),      BW'(expAddr));
        checkOutput("memWriteData", memWriteData,      expWData);
        checkOutput("iBusywait",    BW'(iBusywait),    BW'(iRead && !(inDone && txnOwner == 1)));
        checkOutput("dBusywait",    BW'(dBusywait),
                    BW'((dRead || dWrite) && !(inDone && txnOwner == 2)));
        checkOutput("iReadData",    iReadData,         expIData);
        checkOutput("dReadData",    dReadData,         expDData);
    endtask

    // Advances the model across the coming rising edge using the inputs
    // that were held during the current cycle.
    task automatic modelStep();
        bit wantI;
        bit wantD;
        int winner;
        iSawDone = inDone && txnOwner == 1 && iRead;
        dSawDone = inDone && txnOwner == 2 && (dRead || dWrite);
        wantI    = iRead;
        wantD    = dRead || dWrite;

        if (reset) begin
            modelReset();
        end else if (inDone) begin
            txnOwner = 0;
            doneAt   = -1;
        end else if (txnOwner != 0) begin
            if (cyc > grantAt && !memBusywait) begin
                doneAt = cyc + 1;
                if (!txnIsWrite) begin
                    if (txnOwner == 1) expIData = memReadData;
                    else               expDData = memReadData;
                end
            end
        end else if (wantI || wantD) begin
            if (wantI && wantD) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                winner = (lastWinner == 2) ? 1 : 2;
`else
                winner = 2;
`endif
            end else begin
                winner = wantD ? 2 : 1;
            end
            txnOwner   = winner;
            lastWinner = winner;
            grantAt    = cyc + 1;
            doneAt     = -1;
            txnIsWrite = (winner == 2) && dWrite;
        end
    endtask

    initial begin
        reset       = 1'b1;
        iRead       = 1'b0;
        iAddr       = '0;
        dRead       = 1'b0;
        dWrite      = 1'b0;
        dAddr       = '0;
        dWriteData  = '0;
        memReadData = '0;
        memBusywait = 1'b0;
        cyc         = 0;
        inDone      = 1'b0;
        inGrant     = 1'b0;
        modelReset();

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // The first cycle has no requests, so it checks the reset state.
        @(negedge clock);
        compareCycle();
        modelStep();
        @(posedge clock);
        #1;

        for (cyc = 1; cyc < 2400; cyc++) begin
            applyStimulus();
            @(negedge clock);
            compareCycle();
            modelStep();
            @(posedge clock);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
